// File: rtl/pixel_cache.sv
// pixel_cache: direct-mapped read cache for single-pixel lookups into a
// binary (1 bit per pixel) frame buffer stored as WORD_W-pixel words.
//
// Ports:
//   clk, reset     - clock; synchronous active-high reset
//   x, y, request  - pixel coordinate and level-sensitive lookup request
//   pixel, ready   - looked-up pixel value, valid during the one-cycle ready pulse
//   flush          - invalidates every line (new frame written)
//   mem_addr       - frame-buffer word address, held for the whole miss
//   mem_rd         - one-cycle read strobe
//   mem_rdata      - returned word, bit 0 = leftmost pixel
//   mem_valid      - one-cycle pulse qualifying mem_rdata
`timescale 1ns/1ps
module pixel_cache #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int WORD_W = 32,
    parameter int LINES  = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              request,
    output logic              pixel,
    output logic              ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int WPR   = IMG_W / WORD_W;
    localparam int BIT_W = $clog2(WORD_W);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MISS_REQ,
        MISS_WAIT,
        RESPOND
    } state_t;

    state_t state, next_state;

    logic              req_q;
    logic [9:0]        x_q, y_q;
    logic              last_valid;
    logic [9:0]        last_x, last_y;
    logic              flush_seen;

    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  line_tag  [LINES];
    logic [WORD_W-1:0] line_data [LINES];

    logic              trigger;
    logic              out_of_range;
    logic              hit;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  chk_idx, fill_idx;
    logic [TAG_W-1:0]  chk_tag, fill_tag;
    logic [BIT_W-1:0]  bit_sel;

    logic              pixel_n, ready_n, mem_rd_n, fill;
    logic [ADDR_W-1:0] mem_addr_n;

    // A held request with an unchanged coordinate must not re-trigger; a
    // fresh rising edge or a flushed/empty record always does.
    assign trigger = request &&
                     (!req_q || !last_valid || (x != last_x) || (y != last_y));

    assign out_of_range = (32'(x_q) >= 32'(IMG_W)) || (32'(y_q) >= 32'(IMG_H));
    assign word_addr    = ADDR_W'(32'(y_q) * 32'(WPR) + 32'(x_q >> BIT_W));
    assign chk_idx      = word_addr[IDX_W-1:0];
    assign chk_tag      = word_addr[ADDR_W-1:IDX_W];
    assign bit_sel      = x_q[BIT_W-1:0];
    assign hit          = line_valid[chk_idx] && (line_tag[chk_idx] == chk_tag);

    // The miss address register doubles as the fill address.
    assign fill_idx = mem_addr[IDX_W-1:0];
    assign fill_tag = mem_addr[ADDR_W-1:IDX_W];

    // Next-state and next-output logic; every output is registered below,
    // so values are computed for the state being entered.
    always_comb begin
        next_state = state;
        pixel_n    = pixel;
        ready_n    = 1'b0;
        mem_rd_n   = 1'b0;
        mem_addr_n = mem_addr;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) next_state = CHECK;
            end
            CHECK: begin
                if (out_of_range) begin
                    next_state = RESPOND;
                    ready_n    = 1'b1;
                    pixel_n    = 1'b0;
                end else if (hit) begin
                    next_state = RESPOND;
                    ready_n    = 1'b1;
                    pixel_n    = line_data[chk_idx][bit_sel];
                end else begin
                    next_state = MISS_REQ;
                    mem_rd_n   = 1'b1;
                    mem_addr_n = word_addr;
                end
            end
            MISS_REQ: begin
                next_state = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_valid) begin
                    next_state = RESPOND;
                    ready_n    = 1'b1;
                    pixel_n    = mem_rdata[bit_sel];
                    // Data fetched across a flush may be stale; return it
                    // but do not cache it.
                    fill       = !flush && !flush_seen;
                end
            end
            RESPOND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pixel      <= 1'b0;
            ready      <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            req_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            last_valid <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
            flush_seen <= 1'b0;
            line_valid <= '0;
        end else begin
            state    <= next_state;
            pixel    <= pixel_n;
            ready    <= ready_n;
            mem_rd   <= mem_rd_n;
            mem_addr <= mem_addr_n;
            req_q    <= request;

            if (state == IDLE && trigger) begin
                x_q <= x;
                y_q <= y;
            end

            if (state == RESPOND) begin
                last_valid <= 1'b1;
                last_x     <= x_q;
                last_y     <= y_q;
            end

            if (state == MISS_REQ || state == MISS_WAIT) begin
                flush_seen <= flush_seen | flush;
            end else begin
                flush_seen <= 1'b0;
            end

            if (fill) begin
                line_valid[fill_idx] <= 1'b1;
            end

            // Flush overrides both the fill and the last-served update.
            if (flush) begin
                line_valid <= '0;
                last_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_pixel_cache.sv
// tb_pixel_cache: directed-vector bench for pixel_cache with a behavioural
// frame-buffer responder of programmable read latency.
`timescale 1ns/1ps
module tb_pixel_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        request;
    logic        pixel;
    logic        ready;
    logic        flush;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    pixel_cache #(
        .IMG_W (640),
        .IMG_H (480),
        .WORD_W(32),
        .LINES (8),
        .ADDR_W(14)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .request  (request),
        .pixel    (pixel),
        .ready    (ready),
        .flush    (flush),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    int          lat      = 3;
    int          rd_cnt   = 0;
    logic [13:0] rd_addr  = '0;
    int          n_vec    = 0;
    int          n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read-strobe monitor.
    always @(negedge clk) begin
        if (mem_rd) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= mem_addr;
        end
    end

    // Memory responder: mem_valid arrives lat cycles after the mem_rd cycle.
    initial begin : responder
        logic [13:0] a;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                a = mem_addr;
                repeat (lat) @(posedge clk);
                #1;
                mem_valid = 1'b1;
                mem_rdata = mem[a];
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // One lookup: request rises, waits (bounded) for ready, then drops.
    // k counts edges from the trigger edge (k=1) to the edge that raises ready.
    // flush_k>0 pulses flush for the cycle following edge flush_k.
    task automatic lookup(input int xi, input int yi, input int flush_k,
                          output logic pix, output int k_ready, output int rds);
        int k;
        int base;
        base    = rd_cnt;
        pix     = 1'bx;
        k_ready = -1;
        @(posedge clk);
        #1;
        x       = 10'(xi);
        y       = 10'(yi);
        request = 1'b1;
        k       = 0;
        while (k < 60 && k_ready < 0) begin
            @(posedge clk);
            #1;
            k++;
            flush = (k == flush_k);
            if (ready) begin
                k_ready = k;
                pix     = pixel;
            end
        end
        flush   = 1'b0;
        request = 1'b0;
        rds     = rd_cnt - base;
        if (k_ready < 0) check_eq("lookup_timeout", 32'(k), 32'hFFFF_FFFF);
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    initial begin
        logic        pix;
        int          kr, rds, total, rdy_cnt;
        logic [31:0] w60;

        for (int i = 0; i < 16384; i++) mem[i] = '0;
        mem[0]   = 32'h0000_0020;
        mem[60]  = 32'hF0E1_5A3C;
        mem[61]  = 32'h0000_0001;
        mem[160] = 32'h8000_0001;
        mem[140] = 32'h0000_0080;
        mem[40]  = 32'h0000_0400;
        w60      = mem[60];

        reset = 1'b1; request = 1'b0; flush = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_mem_rd", 32'(mem_rd), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_pixel", 32'(pixel), 0);

        // Cold miss, latency 3.
        lat = 3;
        lookup(5, 0, 0, pix, kr, rds);
        check_eq("cold_pix", 32'(pix), 1);
        check_eq("cold_k", 32'(kr), 6);
        check_eq("cold_rds", 32'(rds), 1);
        check_eq("cold_addr", 32'(rd_addr), 0);
        lookup(4, 0, 0, pix, kr, rds);
        check_eq("hit_pix", 32'(pix), 0);
        check_eq("hit_k", 32'(kr), 2);
        check_eq("hit_rds", 32'(rds), 0);

        // Row scan at y=3: one fetch of word 60 serves all 32 pixels.
        total = 0;
        for (int i = 0; i < 32; i++) begin
            lookup(i, 3, 0, pix, kr, rds);
            total += rds;
            check_eq($sformatf("row_pix_x%0d", i), 32'(pix), 32'(w60[i]));
            if (i == 1) check_eq("row_hit_k", 32'(kr), 2);
        end
        check_eq("row_rds", 32'(total), 1);
        check_eq("row_addr", 32'(rd_addr), 60);
        lookup(32, 3, 0, pix, kr, rds);
        check_eq("row32_rds", 32'(rds), 1);
        check_eq("row32_addr", 32'(rd_addr), 61);
        check_eq("row32_pix", 32'(pix), 1);

        // Conflict on line 0: word 0 vs word 160.
        pulse_flush();
        lookup(0, 0, 0, pix, kr, rds);
        check_eq("conf_a_rds", 32'(rds), 1);
        check_eq("conf_a_pix", 32'(pix), 0);
        lookup(0, 8, 0, pix, kr, rds);
        check_eq("conf_b_rds", 32'(rds), 1);
        check_eq("conf_b_addr", 32'(rd_addr), 160);
        check_eq("conf_b_pix", 32'(pix), 1);
        lookup(0, 0, 0, pix, kr, rds);
        check_eq("conf_c_rds", 32'(rds), 1);
        check_eq("conf_c_addr", 32'(rd_addr), 0);

        // Out of range coordinates.
        lookup(1023, 5, 0, pix, kr, rds);
        check_eq("oor1_pix", 32'(pix), 0);
        check_eq("oor1_k", 32'(kr), 2);
        check_eq("oor1_rds", 32'(rds), 0);
        lookup(640, 0, 0, pix, kr, rds);
        check_eq("oor2_k", 32'(kr), 2);
        check_eq("oor2_rds", 32'(rds), 0);
        lookup(0, 480, 0, pix, kr, rds);
        check_eq("oor3_pix", 32'(pix), 0);
        check_eq("oor3_rds", 32'(rds), 0);

        // Request held at (7,7) long after ready: exactly one ready.
        @(posedge clk);
        #1 x = 10'd7; y = 10'd7; request = 1'b1;
        rdy_cnt = 0;
        pix     = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                rdy_cnt++;
                pix = pixel;
            end
        end
        request = 1'b0;
        check_eq("held_readies", 32'(rdy_cnt), 1);
        check_eq("held_pix", 32'(pix), 1);

        // Flush while waiting on memory: pixel returned, line not filled.
        lat = 5;
        lookup(10, 2, 4, pix, kr, rds);
        check_eq("fmiss_pix", 32'(pix), 1);
        check_eq("fmiss_k", 32'(kr), 8);
        check_eq("fmiss_rds", 32'(rds), 1);
        lat = 2;
        lookup(10, 2, 0, pix, kr, rds);
        check_eq("fmiss_rep_rds", 32'(rds), 1);
        check_eq("fmiss_rep_pix", 32'(pix), 1);
        check_eq("fmiss_rep_k", 32'(kr), 5);

        // Reset while waiting on memory; the late mem_valid must be ignored.
        lat = 6;
        @(posedge clk);
        #1 x = 10'd64; y = 10'd3; request = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1; request = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        rdy_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (ready) rdy_cnt++;
        end
        check_eq("rstmiss_readies", 32'(rdy_cnt), 0);
        check_eq("rstmiss_mem_rd", 32'(mem_rd), 0);
        lat = 2;
        lookup(5, 0, 0, pix, kr, rds);
        check_eq("rstmiss_inval_rds", 32'(rds), 1);
        check_eq("rstmiss_pix", 32'(pix), 1);
        check_eq("rstmiss_k", 32'(kr), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_cache.md
# pixel_cache

Binary-image read cache that serves single-pixel lookups from the edge-search stage. It sits between the edge searcher's pixel request port (`x`, `y`, `request` → `pixel`, `ready`) and the word-wide frame-buffer memory that holds the thresholded frame. It holds a small direct-mapped set of frame words so that consecutive probes along a row or column mostly hit without a memory access.

## Interface

Parameters:

- IMG_W, 640: image width, in pixels.
- IMG_H, 480: image height, in pixels.
- WORD_W, 32: pixels per memory word. Must be a power of 2 and divide IMG_W.
- LINES, 8: number of cache lines. Must be a power of 2.
- ADDR_W, 14: memory word-address width. Must satisfy 2^ADDR_W ≥ IMG_W/WORD_W*IMG_H.

Ports (reset is synchronous, active-high; clock is clk):

- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- x, input, 10: column of the requested pixel.
- y, input, 10: row of the requested pixel.
- request, input, 1: level-sensitive lookup request.
- pixel, output, 1: pixel value. Valid only while ready=1.
- ready, output, 1: one-cycle pulse marking a completed lookup.
- flush, input, 1: invalidates all lines. Pulsed when a new frame has been written.
- mem_addr, output, ADDR_W: word address for the read.
- mem_rd, output, 1: one-cycle read strobe.
- mem_rdata, input, WORD_W: returned word.
- mem_valid, input, 1: one-cycle pulse marking mem_rdata valid. Read latency is variable, at least 1 cycle.

## Operation

- Word address = y*(IMG_W/WORD_W) + x/WORD_W.
- Bit index = x mod WORD_W. Bit 0 is the leftmost pixel of the word.
- Line index = low log2(LINES) bits of the word address. Tag = the remaining bits.
- Each line holds a valid bit, a tag and WORD_W data bits, all in flops.

Trigger rule, evaluated in IDLE only:

- A lookup starts when request=1 AND any of the following holds:
  - request was 0 in the previous cycle;
  - no coordinate has been served since reset or flush;
  - {x,y} differs from the last served coordinate.
- Holding request high with an unchanged coordinate never re-triggers.
- The requester may move x,y only after ready.

State machine: IDLE, CHECK, MISS_REQ, MISS_WAIT, RESPOND.

- IDLE → CHECK on trigger. x and y are latched at this transition.
- CHECK:
  - Out of range (x ≥ IMG_W or y ≥ IMG_H, which includes 10-bit underflow such as 1023) → RESPOND with pixel=0. No memory access.
  - Hit (line valid and tag equal) → RESPOND.
  - Miss → MISS_REQ.
- MISS_REQ: mem_rd=1 for one cycle and mem_addr is driven. → MISS_WAIT.
- MISS_WAIT: mem_addr is held until mem_valid. On mem_valid, the line is filled (valid=1, tag, data) and the pixel bit is selected from mem_rdata. → RESPOND.
- RESPOND: ready=1 and pixel driven for one cycle. The latched coordinate is recorded as last served. → IDLE.

Flush:

- In IDLE, CHECK or RESPOND: all valid bits clear at the next edge. The last-served record clears.
- During MISS_REQ/MISS_WAIT: all valid bits clear. The outstanding read still completes and its pixel is returned, but the line is not filled.
- Flush coincident with a trigger: the flush takes effect first, so the lookup misses.

Other rules:

- mem_valid outside MISS_WAIT is ignored.
- Reset mid-miss returns to IDLE and discards the in-flight read; a late mem_valid is ignored.

Reset values: pixel=0, ready=0, mem_rd=0, mem_addr=0, all valid bits 0, last-served record empty, state IDLE.

## Timing

- Trigger sampled at edge T (end of the IDLE cycle).
- Hit or out-of-range: ready=1 in cycle T+2 (CHECK at T+1, RESPOND at T+2).
- Miss:
  - mem_rd=1 in cycle T+2.
  - mem_valid arrives at cycle M ≥ T+3.
  - ready=1 at cycle M+1.
- ready is never high for two consecutive cycles.
- Minimum spacing between ready pulses is 3 cycles.
- A lookup triggered the cycle after RESPOND is legal: the trigger is evaluated in IDLE and the coordinate must differ.
- All outputs are registered.

## Test plan

- Cold miss: reset, then memory word 0 = 32'h0000_0020 with latency 3. Request (5,0): mem_rd with mem_addr=0 at T+2; mem_valid at T+5; ready with pixel=1 at T+6. Request (4,0) → hit, ready at T+2, pixel=0, no mem_rd.
- Row scan: x=0..31 in sequence at y=3 → exactly one mem_rd (addr 60). Each hit returns the correct bit. x=32 → miss at addr 61.
- Conflict: (0,0) then (0,8) with LINES=8. Word addresses 0 and 160 share index 0, so each is a miss. Re-request (0,0) → miss again.
- Out of range: x=1023, y=5 and x=640, y=0 → pixel=0 and ready at T+2, no mem_rd.
- Request held high at (7,7) for 20 cycles after ready → no further ready.
- Flush during MISS_WAIT: the read completes with the correct pixel, but a repeat request to the same address → miss. Reset during MISS_WAIT with a later stray mem_valid → no ready, state IDLE, all lines invalid.
